// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage between execute and register writeback
// Loads/stores go to the data cache via a valid/ready request and a response ack.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      ex_rd,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            flush,
  output logic            dc_req_valid,
  input  logic            dc_req_ready,
  output logic            dc_req_we,
  output logic [XLEN-1:0] dc_req_addr,
  output logic [XLEN-1:0] dc_req_wdata,
  output logic [7:0]      dc_req_be,
  input  logic            dc_resp_valid,
  input  logic [XLEN-1:0] dc_resp_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [PC_W-1:0] wb_pc,
  output logic            wb_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  logic            drop_q, drop_d;
  logic            ld_q, ld_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [2:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ex_ready_q, ex_ready_d;
  logic            req_valid_q, req_valid_d;
  logic            req_we_q, req_we_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [7:0]      req_be_q, req_be_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_mis_q, wb_mis_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [PC_W-1:0] wb_pc_q, wb_pc_d;

  logic            is_mem;
  logic            misaligned;
  logic [7:0]      be_base;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_val;

  // Per-size alignment check, byte-enable base mask and lane replication of store data.
  always_comb begin
    is_mem = ex_is_load | ex_is_store;
    case (ex_size)
      2'd0: begin misaligned = 1'b0;          be_base = 8'h01; wdata_rep = {8{ex_store_data[7:0]}};  end
      2'd1: begin misaligned = ex_addr[0];    be_base = 8'h03; wdata_rep = {4{ex_store_data[15:0]}}; end
      2'd2: begin misaligned = |ex_addr[1:0]; be_base = 8'h0F; wdata_rep = {2{ex_store_data[31:0]}}; end
      default: begin misaligned = |ex_addr[2:0]; be_base = 8'hFF; wdata_rep = ex_store_data; end
    endcase
  end

  always_comb begin
    lane = dc_resp_data >> {off_q, 3'b000};
    case (size_q)
      2'd0: load_val = uns_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
      2'd1: load_val = uns_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2: load_val = uns_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    ld_d        = ld_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    wb_valid_d  = 1'b0;
    wb_mis_d    = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_pc_d     = wb_pc_q;
    case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
            wb_pc_d    = ex_pc;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_mis_d   = 1'b1;
            wb_rd_d    = 5'd0;
            wb_data_d  = ex_addr;
            wb_pc_d    = ex_pc;
          end else begin
            state_d     = REQ;
            drop_d      = 1'b0;
            ld_d        = ex_is_load;
            size_d      = ex_size;
            uns_d       = ex_unsigned;
            off_d       = ex_addr[2:0];
            rd_d        = ex_rd;
            pc_d        = ex_pc;
            req_valid_d = 1'b1;
            req_we_d    = ex_is_store;
            req_addr_d  = {ex_addr[XLEN-1:3], 3'b000};
            req_wdata_d = ex_is_store ? wdata_rep : '0;
            req_be_d    = be_base << ex_addr[2:0];
          end
        end
      end
      REQ: begin
        // A request the cache has already taken must still be drained, even when flushed.
        if (dc_req_ready) begin
          state_d     = RESP;
          req_valid_d = 1'b0;
          drop_d      = flush;
        end else if (flush) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
        end
      end
      RESP: begin
        if (flush) drop_d = 1'b1;
        if (dc_resp_valid) begin
          state_d = IDLE;
          if (!drop_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = pc_q;
            wb_rd_d    = ld_q ? rd_q : 5'd0;
            wb_data_d  = ld_q ? load_val : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ex_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      ld_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 3'd0;
      rd_q        <= 5'd0;
      pc_q        <= '0;
      ex_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_mis_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      wb_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      ld_q        <= ld_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      ex_ready_q  <= ex_ready_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_mis_q    <= wb_mis_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_pc_q     <= wb_pc_d;
    end
  end

  assign ex_ready      = ex_ready_q;
  assign dc_req_valid  = req_valid_q;
  assign dc_req_we     = req_we_q;
  assign dc_req_addr   = req_addr_q;
  assign dc_req_wdata  = req_wdata_q;
  assign dc_req_be     = req_be_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign wb_pc         = wb_pc_q;
  assign wb_misaligned = wb_mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
// Directed vector table, randomized transactions against a byte-level model, flush/reset sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [1:0]  ex_size = 2'd0;
  logic        ex_unsigned = 1'b0;
  logic [63:0] ex_addr = '0, ex_store_data = '0, ex_result = '0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_pc = '0;
  logic        flush = 1'b0;
  logic        dc_req_valid, dc_req_ready = 1'b0, dc_req_we;
  logic [63:0] dc_req_addr, dc_req_wdata;
  logic [7:0]  dc_req_be;
  logic        dc_resp_valid = 1'b0;
  logic [63:0] dc_resp_data = '0;
  logic        wb_valid, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] wb_pc;

  int n_vec = 0;
  int n_mis = 0;

  mem_stage #(.XLEN(64), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_result(ex_result), .ex_rd(ex_rd), .ex_pc(ex_pc), .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic st; logic [1:0] size; logic uns;
    logic [63:0] addr; logic [63:0] sdata; logic [63:0] result; logic [4:0] rd; logic [31:0] pc;
    logic [63:0] resp; int rdly; int sdly;
    logic e_req; logic e_mis; logic [4:0] e_rd; logic [63:0] e_data; logic [7:0] e_be; logic [63:0] e_wdata;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte-by-byte reference: what each lane of memory should see and what the load returns.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int nb = 1 << v.size;
    int off = int'(v.addr[2:0]);
    logic [63:0] val = '0;
    logic mem = v.ld || v.st;
    r.e_mis = mem && ((v.addr % 64'(nb)) != 0);
    r.e_req = mem && !r.e_mis;
    r.e_be = '0;
    r.e_wdata = '0;
    if (!mem) begin
      r.e_rd = v.rd; r.e_data = v.result;
    end else if (r.e_mis) begin
      r.e_rd = 5'd0; r.e_data = v.addr;
    end else if (v.ld) begin
      for (int i = 0; i < nb; i++) val[8*i +: 8] = v.resp[8*(off+i) +: 8];
      if (nb < 8 && !v.uns && val[8*nb-1]) for (int i = 8*nb; i < 64; i++) val[i] = 1'b1;
      r.e_rd = v.rd; r.e_data = val;
    end else begin
      r.e_rd = 5'd0; r.e_data = '0;
    end
    if (v.st) for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + nb) r.e_be[i] = 1'b1;
      r.e_wdata[8*i +: 8] = v.sdata[8*(i % nb) +: 8];
    end
    return r;
  endfunction

  // Drives one instruction and plays the cache; all waits bounded by the loop budget.
  task automatic apply(input vec_t v);
    bit got_wb = 0, req_seen = 0, hs = 0, sent = 0, stable = 1, extra = 0, rdy_bad = 0;
    logic mis = 0, we = 0;
    logic [4:0] rd = '0;
    logic [63:0] data = '0, a = '0, wd = '0;
    logic [31:0] pc = '0;
    logic [7:0] be = '0;
    int wr = 0, ws = 0, lat = 0;
    @(negedge clk);
    chk("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_is_load = v.ld; ex_is_store = v.st; ex_size = v.size; ex_unsigned = v.uns;
    ex_addr = v.addr; ex_store_data = v.sdata; ex_result = v.result; ex_rd = v.rd; ex_pc = v.pc;
    @(negedge clk);
    ex_valid = 1'b0;
    for (int c = 0; c < 60 && !got_wb; c++) begin
      dc_req_ready = 1'b0;
      dc_resp_valid = 1'b0;
      if (wb_valid) begin
        got_wb = 1; lat = c + 1;
        mis = wb_misaligned; rd = wb_rd; data = wb_data; pc = wb_pc;
        if (!ex_ready) rdy_bad = 1;
      end else begin
        if (hs && dc_req_valid) extra = 1;
        if (!hs && dc_req_valid) begin
          if (!req_seen) begin
            req_seen = 1; a = dc_req_addr; wd = dc_req_wdata; be = dc_req_be; we = dc_req_we;
          end else if ({a, wd, be, we} !== {dc_req_addr, dc_req_wdata, dc_req_be, dc_req_we}) stable = 0;
          if (ex_ready) rdy_bad = 1;
          if (wr == v.rdly) begin dc_req_ready = 1'b1; hs = 1; end else wr++;
        end else if (hs && !sent) begin
          if (ex_ready) rdy_bad = 1;
          if (ws == v.sdly) begin
            dc_resp_valid = 1'b1; dc_resp_data = v.resp; sent = 1;
          end else begin
            ws++; dc_resp_data = {$urandom, $urandom};
          end
        end
        @(negedge clk);
      end
    end
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0;
    chk("wb_seen", 64'(got_wb), 64'd1);
    chk("wb_misaligned", 64'(mis), 64'(v.e_mis));
    chk("wb_rd", 64'(rd), 64'(v.e_rd));
    chk("wb_data", data, v.e_data);
    chk("wb_pc", 64'(pc), 64'(v.pc));
    chk("req_seen", 64'(req_seen), 64'(v.e_req));
    chk("ex_ready_busy", 64'(rdy_bad), 64'd0);
    if (v.e_req) begin
      chk("req_addr", a, v.addr & ~64'h7);
      chk("req_we", 64'(we), 64'(v.st));
      chk("req_stable", 64'(stable), 64'd1);
      chk("single_req", 64'(extra), 64'd0);
      chk("mem_latency", 64'(lat), 64'(3 + v.rdly + v.sdly));
      if (v.st) begin
        chk("req_be", 64'(be), 64'(v.e_be));
        chk("req_wdata", wd, v.e_wdata);
      end
    end else begin
      chk("pass_latency", 64'(lat), 64'd1);
    end
  endtask

  task automatic issue_ld(input logic [63:0] addr);
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_size = 2'd3; ex_unsigned = 1'b0;
    ex_addr = addr; ex_rd = 5'd1; ex_pc = 32'h200;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit any_wb;
    //         ld st sz un addr         sdata                  result   rd  pc       resp                   rdly sdly req mis erd edata                  ebe    ewdata
    tbl[0]  = '{0, 0, 0, 0, 64'h0,    64'h0,                 64'h1234, 5,  32'h100, 64'h0,                 0, 0, 0, 0, 5,  64'h1234,              8'h00, 64'h0};
    tbl[1]  = '{1, 0, 0, 0, 64'h1003, 64'h0,                 64'h0,    7,  32'h104, 64'h8000_0000,         0, 0, 1, 0, 7,  64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
    tbl[2]  = '{1, 0, 0, 1, 64'h1003, 64'h0,                 64'h0,    8,  32'h108, 64'h8000_0000,         0, 0, 1, 0, 8,  64'h80,                8'h00, 64'h0};
    tbl[3]  = '{0, 1, 1, 0, 64'h2006, 64'hABCD,              64'h0,    9,  32'h10C, 64'h0,                 0, 0, 1, 0, 0,  64'h0,                 8'hC0, 64'hABCD_ABCD_ABCD_ABCD};
    tbl[4]  = '{1, 0, 2, 0, 64'h3002, 64'h0,                 64'h0,    3,  32'h110, 64'h0,                 0, 0, 0, 1, 0,  64'h3002,              8'h00, 64'h0};
    tbl[5]  = '{1, 0, 3, 0, 64'h4008, 64'h0,                 64'h0,    10, 32'h114, 64'h1122_3344_5566_7788, 4, 0, 1, 0, 10, 64'h1122_3344_5566_7788, 8'h00, 64'h0};
    tbl[6]  = '{1, 0, 2, 0, 64'h5004, 64'h0,                 64'h0,    11, 32'h118, 64'h8765_4321_0000_0000, 0, 1, 1, 0, 11, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0};
    tbl[7]  = '{1, 0, 1, 1, 64'h6002, 64'h0,                 64'h0,    12, 32'h11C, 64'h0000_0000_F00D_0000, 1, 2, 1, 0, 12, 64'hF00D,              8'h00, 64'h0};
    tbl[8]  = '{0, 1, 3, 0, 64'h7000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,  13, 32'h120, 64'h0,                 2, 1, 1, 0, 0,  64'h0,                 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[9]  = '{0, 1, 0, 0, 64'h8005, 64'h1234_565A,         64'h0,    14, 32'h124, 64'h0,                 0, 0, 1, 0, 0,  64'h0,                 8'h20, 64'h5A5A_5A5A_5A5A_5A5A};
    tbl[10] = '{0, 1, 3, 0, 64'h9004, 64'h55,                64'h0,    15, 32'h128, 64'h0,                 0, 0, 0, 1, 0,  64'h9004,              8'h00, 64'h0};
    tbl[11] = '{1, 0, 3, 0, 64'hA000, 64'h0,                 64'h0,    0,  32'h12C, 64'h42,                0, 0, 1, 0, 0,  64'h42,                8'h00, 64'h0};
    tbl[12] = '{1, 0, 3, 1, 64'hA008, 64'h0,                 64'h0,    4,  32'h130, 64'h8000_0000_0000_0001, 0, 0, 1, 0, 4,  64'h8000_0000_0000_0001, 8'h00, 64'h0};
    tbl[13] = '{1, 0, 1, 0, 64'hB00E, 64'h0,                 64'h0,    6,  32'h134, 64'h8001_0000_0000_0000, 0, 0, 1, 0, 6,  64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_misaligned", 64'(wb_misaligned), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_req_be", 64'(dc_req_be), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Flush in RESP: response arrives three cycles after the flush and is swallowed.
    any_wb = 0;
    issue_ld(64'hB000);
    chk("fr_req_valid", 64'(dc_req_valid), 64'd1);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      any_wb |= wb_valid;
      chk("fr_drain_not_ready", 64'(ex_ready), 64'd0);
      @(negedge clk);
    end
    chk("fr_drain_not_ready", 64'(ex_ready), 64'd0);
    dc_resp_valid = 1'b1; dc_resp_data = 64'h1234;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    any_wb |= wb_valid;
    chk("fr_ready_back", 64'(ex_ready), 64'd1);
    chk("fr_no_wb", 64'(any_wb), 64'd0);

    // Flush in REQ before the cache is ready; a stray response afterwards is ignored.
    issue_ld(64'hB100);
    chk("fq_req_valid", 64'(dc_req_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fq_req_dropped", 64'(dc_req_valid), 64'd0);
    chk("fq_ready", 64'(ex_ready), 64'd1);
    dc_resp_valid = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    chk("fq_no_wb", 64'(wb_valid), 64'd0);

    // Flush coinciding with the response in RESP.
    issue_ld(64'hB200);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    flush = 1'b1; dc_resp_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; dc_resp_valid = 1'b0;
    chk("fs_no_wb", 64'(wb_valid), 64'd0);
    chk("fs_ready", 64'(ex_ready), 64'd1);

    // Flush in IDLE drops the incoming instruction.
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_result = 64'h77; ex_rd = 5'd2; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    chk("fi_no_wb", 64'(wb_valid), 64'd0);

    // Reset while the response is outstanding; the late response must not retire.
    issue_ld(64'hB300);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm_ready", 64'(ex_ready), 64'd1);
    dc_resp_valid = 1'b1;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    chk("rm_no_wb", 64'(wb_valid), 64'd0);
    chk("rm_no_req", 64'(dc_req_valid), 64'd0);

    for (int k = 0; k < 150; k++) begin
      int op = $urandom_range(0, 2);
      v.ld = (op == 1); v.st = (op == 2);
      v.size = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((64'd1 << v.size) - 64'd1);
      v.sdata = {$urandom, $urandom};
      v.result = {$urandom, $urandom};
      v.resp = {$urandom, $urandom};
      v.rd = 5'($urandom_range(0, 31));
      v.pc = $urandom;
      v.rdly = $urandom_range(0, 3);
      v.sdly = $urandom_range(0, 3);
      apply(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage sitting directly downstream of the execute/ALU stage and upstream of register writeback. It accepts one executed instruction at a time. Loads and stores go to the data-cache port through a valid/ready request and a response handshake. Non-memory results pass through with one-cycle latency. The stage back-pressures execute while an access is outstanding.

Parameters:
XLEN, 64, data/address width (only 64 supported)
PC_W, 32, program-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  execute output valid
ex_ready  out  1  stage can accept this cycle
ex_is_load  in  1  instruction is a load
ex_is_store  in  1  instruction is a store
ex_size  in  2  0=byte,1=half,2=word,3=double
ex_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
ex_addr  in  XLEN  effective address
ex_store_data  in  XLEN  store source value
ex_result  in  XLEN  ALU result for non-memory ops
ex_rd  in  5  destination register
ex_pc  in  PC_W  instruction PC
flush  in  1  pipeline flush
dc_req_valid  out  1  cache request valid
dc_req_ready  in  1  cache accepts request
dc_req_we  out  1  1=store
dc_req_addr  out  XLEN  {ex_addr[63:3],3'b000}
dc_req_wdata  out  XLEN  lane-aligned store data
dc_req_be  out  8  byte enables
dc_resp_valid  in  1  response/ack (loads and stores)
dc_resp_data  in  XLEN  8-byte aligned load data
wb_valid  out  1  writeback valid (one-cycle pulse)
wb_rd  out  5  writeback register (0 = no write)
wb_data  out  XLEN  writeback value
wb_pc  out  PC_W  PC of retiring instruction
wb_misaligned  out  1  misaligned-access exception flag

Behaviour:
- Reset: state IDLE. All outputs 0 except ex_ready=1.
- States: IDLE, REQ, RESP. ex_ready=1 only in IDLE.
- IDLE, ex_valid, no flush, non-memory op: next cycle wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_pc=ex_pc. Stay IDLE.
- IDLE, ex_valid, no flush, memory op: capture all ex_* fields and check alignment. Alignment requires addr[0]=0 for half, addr[1:0]=0 for word, addr[2:0]=0 for double.
  - Misaligned: no cache request. Next cycle wb_valid=1, wb_misaligned=1, wb_rd=0, wb_data=ex_addr. Stay IDLE.
  - Aligned: go to REQ.
- REQ: dc_req_valid=1. Request fields are held stable until dc_req_ready. On dc_req_valid&&dc_req_ready, go to RESP. Zero-wait accept is allowed.
- Store encoding:
  - dc_req_be = {1,3,15,255}[size] << addr[2:0].
  - dc_req_wdata = store data replicated across lanes (byte x8, half x4, word x2, double x1).
- RESP: wait for dc_resp_valid, then return to IDLE. wb_valid pulses in the cycle after dc_resp_valid.
  - Load: byte lane = dc_resp_data >> (8*addr[2:0]), truncated to size. Sign-extend unless ex_unsigned; double ignores ex_unsigned. wb_rd = captured rd (rd=0 still accesses memory).
  - Store: wb_rd=0, wb_data=0.
- Minimum load-to-writeback latency is 3 cycles after acceptance (REQ, RESP, WB), assuming zero-wait cache.
- Flush handling:
  - In IDLE: drop the incoming instruction; no wb_valid next cycle.
  - In REQ: abort; dc_req_valid deasserts next cycle, return to IDLE, no writeback.
  - In RESP (request already accepted): set drop flag, keep waiting for dc_resp_valid, return to IDLE, suppress wb_valid. ex_ready stays 0 until the drain completes.
- dc_resp_valid outside RESP is ignored.
- Simultaneous dc_resp_valid and flush in RESP: response consumed, writeback suppressed.
- Reset mid-operation: immediate return to IDLE. Any outstanding response arriving after reset is ignored.
- wb_misaligned is 0 on every wb_valid except the misaligned case.

Test Plan:
- ALU pass-through: ex_result=0x1234, rd=5, pc=0x100 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, wb_pc=0x100, ex_ready stays 1.
- lb signed: addr=0x1003, resp_data=0x0000_0000_8000_0000, ready immediate -> wb_data=0xFFFF_FFFF_FFFF_FF80. Same with lbu -> 0x80.
- sh: addr=0x2006, data=0xABCD -> dc_req_be=0xC0, wdata=0xABCD_ABCD_ABCD_ABCD, dc_req_addr=0x2000, we=1; after resp, wb_rd=0.
- Back-pressure: dc_req_ready low 4 cycles -> dc_req_valid and all request fields stable, ex_ready=0 throughout; single request handshake.
- Misaligned lw addr=0x3002 -> no dc_req_valid, next cycle wb_valid=1, wb_misaligned=1, wb_data=0x3002.
- Flush in RESP: ld accepted, flush pulsed, resp 3 cycles later -> no wb_valid; ex_ready returns 1 cycle after resp. Flush in REQ before ready -> dc_req_valid drops next cycle.
